pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/stall controller that drives the write-enable and bubble side of the IF/ID, ID/EXE and EXE/MEM pipe registers.
//  Consumes the destination info those registers carry (rf_we, rf_waddr, rf_data_sel) at EXE, MEM and WB.
//  Produces operand-forwarding selects for the ID-stage rs/rt and detects load-use hazards.
//  Sequences multi-cycle MULT/DIV stalls with a small FSM, and keeps a stall-cycle performance counter.
// PARAMETERS
//  MD_CYCLES   4    EXE-stage freeze cycles per MULT/DIV op; must be >=2.
//  CNT_W       32   width of stall_count.
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-high
//  id_rs_addr     in   5      ID-stage rs index
//  id_rt_addr     in   5      ID-stage rt index
//  id_uses_rs     in   1      ID instruction reads rs
//  id_uses_rt     in   1      ID instruction reads rt
//  exe_rf_we      in   1      EXE instruction writes the regfile
//  exe_rf_waddr   in   5      EXE destination register
//  exe_rf_data_sel in  1      1 = EXE instruction is a load (result comes from dmem)
//  exe_is_md      in   1      MULT/DIV op is resident in EXE (level)
//  mem_rf_we      in   1      MEM instruction writes the regfile
//  mem_rf_waddr   in   5      MEM destination register
//  wb_rf_we       in   1      WB instruction writes the regfile
//  wb_rf_waddr    in   5      WB destination register
//  pc_we          out  1      PC update enable
//  iireg_we       out  1      IF/ID register write enable
//  iereg_we       out  1      ID/EXE register write enable
//  id_bubble      out  1      1 = datapath forces id_rf_we/id_dmem_we to 0 into ID/EXE
//  exe_bubble     out  1      1 = datapath forces exe_rf_we/exe_dmem_we to 0 into EXE/MEM
//  fwd_rs_sel     out  2      00 regfile, 01 exe_Z, 10 MEM result, 11 WB result
//  fwd_rt_sel     out  2      same encoding as fwd_rs_sel, for rt
//  md_busy        out  1      FSM is in MD_BUSY
//  stall_count    out  CNT_W  cycles with pc_we==0 since reset; saturates at all-ones
// BEHAVIOUR
//  FSM states (state reg + cnt reg):
//   RUN:     exe_is_md=1 -> freeze this cycle; cnt<=MD_CYCLES-1; next MD_BUSY.
//   MD_BUSY: freeze; cnt==1 -> next MD_DONE, else cnt<=cnt-1.
//   MD_DONE: no md freeze, exe_is_md ignored (md op leaves EXE); next RUN.
//   Total freeze = exactly MD_CYCLES cycles per md op, followed by one release cycle.
//  Freeze outputs: pc_we=iireg_we=iereg_we=0, exe_bubble=1, id_bubble=0.
//  Load-use hazard (combinational):
//   condition: exe_rf_we & exe_rf_data_sel & exe_rf_waddr!=0 &
//     ((id_uses_rs & rs==exe_rf_waddr) | (id_uses_rt & rt==exe_rf_waddr)).
//   response: pc_we=iireg_we=0, iereg_we=1, id_bubble=1. Single cycle; clears once the load moves to MEM.
//  Priority: md freeze > load-use > normal (all enables 1, both bubbles 0).
//  Forwarding, per operand (rs shown; rt identical), combinational, first match wins:
//   exe_rf_we & !exe_rf_data_sel & waddr==rs -> 01
//   else mem_rf_we & mem_rf_waddr==rs -> 10
//   else wb_rf_we & wb_rf_waddr==rs -> 11
//   else 00
//   Register 0 never matches: sel=00 whenever the address is 0. Selects are valid during stalls.
//  stall_count: +1 on each clock edge where pc_we==0; holds at max.
//  Reset (async, immediate):
//   state=RUN, cnt=0, stall_count=0.
//   While reset is high: pc_we=iireg_we=iereg_we=0, bubbles=0, fwd sels=00, md_busy=0.
//   Reset during MD_BUSY aborts the sequence; first post-reset cycle is RUN.
// TESTING
//  1 Reset pulse, then idle inputs -> pc_we=iireg_we=iereg_we=1, bubbles 0, fwd 00, stall_count=0.
//  2 EXE add r5 (we=1,data_sel=0), MEM also writes r5, ID rs=5 -> fwd_rs_sel=01, no stall.
//    Drop EXE match -> fwd_rs_sel=10.
//  3 EXE lw r8 (data_sel=1), ID rt=8 uses_rt -> 1 cycle pc_we=iireg_we=0, id_bubble=1.
//    Next cycle (lw now in MEM) -> fwd_rt_sel=10, no stall; stall_count=1.
//  4 EXE lw r0, ID rs=0 uses_rs -> no stall, fwd_rs_sel=00.
//    WB writes r3, ID rt=3 -> fwd_rt_sel=11.
//  5 MD_CYCLES=4, exe_is_md held high -> 4 cycles freeze with exe_bubble=1, md_busy on cycles 2-4.
//    5th cycle all enables 1; stall_count +=4; no retrigger.
//  6 Reset asserted in 2nd freeze cycle -> outputs drop to reset values immediately.
//    Release with exe_is_md=0 -> RUN, enables 1, stall_count=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use stall, MULT/DIV freeze
// sequencing and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             exe_rf_we,
  input  logic [4:0]       exe_rf_waddr,
  input  logic             exe_rf_data_sel,
  input  logic             exe_is_md,
  input  logic             mem_rf_we,
  input  logic [4:0]       mem_rf_waddr,
  input  logic             wb_rf_we,
  input  logic [4:0]       wb_rf_waddr,
  output logic             pc_we,
  output logic             iireg_we,
  output logic             iereg_we,
  output logic             id_bubble,
  output logic             exe_bubble,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned MdCntW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

  typedef enum logic [1:0] {StRun, StMdBusy, StMdDone} md_state_e;

  md_state_e         state_q, state_d;
  logic [MdCntW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_count_q;
  logic              md_freeze;
  logic              load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] addr);
    if (addr == 5'd0) begin
      return 2'b00;
    end else if (exe_rf_we && !exe_rf_data_sel && exe_rf_waddr == addr) begin
      return 2'b01;
    end else if (mem_rf_we && mem_rf_waddr == addr) begin
      return 2'b10;
    end else if (wb_rf_we && wb_rf_waddr == addr) begin
      return 2'b11;
    end
    return 2'b00;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_freeze = 1'b0;
    unique case (state_q)
      StRun: begin
        if (exe_is_md) begin
          md_freeze = 1'b1;
          cnt_d     = MdCntW'(MD_CYCLES - 1);
          state_d   = StMdBusy;
        end
      end
      StMdBusy: begin
        md_freeze = 1'b1;
        if (cnt_q == MdCntW'(1)) begin
          state_d = StMdDone;
        end else begin
          cnt_d = cnt_q - MdCntW'(1);
        end
      end
      StMdDone: begin
        // md op is leaving EXE this cycle; exe_is_md must not retrigger.
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  assign load_use = exe_rf_we && exe_rf_data_sel && (exe_rf_waddr != 5'd0) &&
                    ((id_uses_rs && id_rs_addr == exe_rf_waddr) ||
                     (id_uses_rt && id_rt_addr == exe_rf_waddr));

  always_comb begin
    pc_we      = 1'b1;
    iireg_we   = 1'b1;
    iereg_we   = 1'b1;
    id_bubble  = 1'b0;
    exe_bubble = 1'b0;
    fwd_rs_sel = fwd_sel(id_rs_addr);
    fwd_rt_sel = fwd_sel(id_rt_addr);
    if (reset) begin
      pc_we      = 1'b0;
      iireg_we   = 1'b0;
      iereg_we   = 1'b0;
      fwd_rs_sel = 2'b00;
      fwd_rt_sel = 2'b00;
    end else if (md_freeze) begin
      pc_we      = 1'b0;
      iireg_we   = 1'b0;
      iereg_we   = 1'b0;
      exe_bubble = 1'b1;
    end else if (load_use) begin
      pc_we     = 1'b0;
      iireg_we  = 1'b0;
      id_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StRun;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_we && stall_count_q != {CNT_W{1'b1}}) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
    end
  end

  assign md_busy     = (state_q == StMdBusy);
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs change just after each falling edge and outputs
// are checked 1 time unit later, well away from the rising edge.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs_addr, id_rt_addr;
  logic        id_uses_rs, id_uses_rt;
  logic        exe_rf_we, exe_rf_data_sel, exe_is_md;
  logic [4:0]  exe_rf_waddr;
  logic        mem_rf_we, wb_rf_we;
  logic [4:0]  mem_rf_waddr, wb_rf_waddr;
  logic        pc_we, iireg_we, iereg_we, id_bubble, exe_bubble, md_busy;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs_addr      (id_rs_addr),
    .id_rt_addr      (id_rt_addr),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .exe_rf_we       (exe_rf_we),
    .exe_rf_waddr    (exe_rf_waddr),
    .exe_rf_data_sel (exe_rf_data_sel),
    .exe_is_md       (exe_is_md),
    .mem_rf_we       (mem_rf_we),
    .mem_rf_waddr    (mem_rf_waddr),
    .wb_rf_we        (wb_rf_we),
    .wb_rf_waddr     (wb_rf_waddr),
    .pc_we           (pc_we),
    .iireg_we        (iireg_we),
    .iereg_we        (iereg_we),
    .id_bubble       (id_bubble),
    .exe_bubble      (exe_bubble),
    .fwd_rs_sel      (fwd_rs_sel),
    .fwd_rt_sel      (fwd_rt_sel),
    .md_busy         (md_busy),
    .stall_count     (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the full control bundle {pc_we, iireg_we, iereg_we, id_bubble, exe_bubble}.
  task automatic chk_ctrl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_we, iireg_we, iereg_we, id_bubble, exe_bubble}, {27'd0, exp});
  endtask

  task automatic idle();
    id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    exe_rf_we = 1'b0; exe_rf_waddr = 5'd0; exe_rf_data_sel = 1'b0; exe_is_md = 1'b0;
    mem_rf_we = 1'b0; mem_rf_waddr = 5'd0; wb_rf_we = 1'b0; wb_rf_waddr = 5'd0;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    chk_ctrl("in_reset_ctrl", 5'b00000);
    chk("in_reset_md_busy", {31'd0, md_busy}, 32'd0);
    next(); next();
    reset = 1'b0;
    #1;
    chk_ctrl("idle_ctrl", 5'b11100);
    chk("idle_fwd", {28'd0, fwd_rs_sel, fwd_rt_sel}, 32'd0);
    chk("idle_count", stall_count, 32'd0);

    // EXE ALU result wins over MEM for the same register.
    next();
    exe_rf_we = 1'b1; exe_rf_waddr = 5'd5; mem_rf_we = 1'b1; mem_rf_waddr = 5'd5;
    id_rs_addr = 5'd5; id_uses_rs = 1'b1;
    #1;
    chk("fwd_exe", {30'd0, fwd_rs_sel}, 32'd1);
    chk_ctrl("fwd_exe_ctrl", 5'b11100);
    next();
    exe_rf_we = 1'b0;
    #1;
    chk("fwd_mem", {30'd0, fwd_rs_sel}, 32'd2);

    // Load-use: one stall cycle, then forward from MEM.
    next();
    idle();
    exe_rf_we = 1'b1; exe_rf_waddr = 5'd8; exe_rf_data_sel = 1'b1;
    id_rt_addr = 5'd8; id_uses_rt = 1'b1;
    #1;
    chk_ctrl("load_use_ctrl", 5'b00110);
    chk("load_use_no_exe_fwd", {30'd0, fwd_rt_sel}, 32'd0);
    next();
    exe_rf_we = 1'b0; exe_rf_data_sel = 1'b0; mem_rf_we = 1'b1; mem_rf_waddr = 5'd8;
    #1;
    chk_ctrl("after_load_ctrl", 5'b11100);
    chk("after_load_fwd", {30'd0, fwd_rt_sel}, 32'd2);
    chk("after_load_count", stall_count, 32'd1);

    // r0 never stalls nor forwards; WB forwarding.
    next();
    idle();
    exe_rf_we = 1'b1; exe_rf_data_sel = 1'b1; exe_rf_waddr = 5'd0;
    mem_rf_we = 1'b1; mem_rf_waddr = 5'd0;
    id_rs_addr = 5'd0; id_uses_rs = 1'b1;
    #1;
    chk_ctrl("r0_ctrl", 5'b11100);
    chk("r0_fwd", {30'd0, fwd_rs_sel}, 32'd0);
    next();
    idle();
    wb_rf_we = 1'b1; wb_rf_waddr = 5'd3; id_rt_addr = 5'd3; id_uses_rt = 1'b1;
    #1;
    chk("fwd_wb", {30'd0, fwd_rt_sel}, 32'd3);

    // MULT/DIV: 4 freeze cycles, then a release cycle with exe_is_md still high.
    next();
    exe_is_md = 1'b1;
    #1;
    chk_ctrl("md_c1_ctrl", 5'b00001);
    chk("md_c1_busy", {31'd0, md_busy}, 32'd0);
    chk("md_fwd_during_stall", {30'd0, fwd_rt_sel}, 32'd3);
    for (int c = 2; c <= 4; c++) begin
      next();
      #1;
      chk($sformatf("md_c%0d_ctrl", c), {27'd0, pc_we, iireg_we, iereg_we, id_bubble,
          exe_bubble}, 32'b00001);
      chk($sformatf("md_c%0d_busy", c), {31'd0, md_busy}, 32'd1);
    end
    next();
    #1;
    chk_ctrl("md_release_ctrl", 5'b11100);
    chk("md_release_busy", {31'd0, md_busy}, 32'd0);
    chk("md_count", stall_count, 32'd5);
    next();
    exe_is_md = 1'b0;
    #1;
    chk_ctrl("md_after_ctrl", 5'b11100);
    chk("md_after_count", stall_count, 32'd5);

    // Reset in the second freeze cycle aborts the sequence.
    next();
    exe_is_md = 1'b1;
    next();
    #1;
    chk("abort_busy_pre", {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk_ctrl("abort_reset_ctrl", 5'b00000);
    chk("abort_reset_busy", {31'd0, md_busy}, 32'd0);
    chk("abort_reset_fwd", {30'd0, fwd_rt_sel}, 32'd0);
    chk("abort_reset_count", stall_count, 32'd0);
    next();
    reset = 1'b0; exe_is_md = 1'b0;
    #1;
    chk_ctrl("post_reset_ctrl", 5'b11100);
    chk("post_reset_busy", {31'd0, md_busy}, 32'd0);
    next();
    #1;
    chk_ctrl("post_reset_run_ctrl", 5'b11100);
    chk("post_reset_count", stall_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
